rst_sequencer: RTL and testbench
================================

# rst_sequencer

Synthesizable reset sequencer that turns the one system reset into STAGES ordered reset outputs. After reset is released, or after a software reset request, all stages are held asserted for HOLD_CYCLES cycles. The stages are then released one at a time, lowest index first, HOLD_CYCLES apart. It sits at the top of each design, between the system reset (driven by the testbench reset source in simulation) and the downstream reset domains.

## Interface
- STAGES, default 4: number of sequenced reset outputs, 1..16.
- HOLD_CYCLES, default 16: hold-off before each release, in clk cycles, ≥1.
- CNT_W, default 8: hold counter width; must satisfy HOLD_CYCLES-1 < 2^CNT_W, otherwise elaboration error.
- ACTIVE_HIGH, default "YES": polarity of rst_out. "YES" means asserted = 1; anything else means asserted = 0.

- clk  in  1  single clock for all logic.
- rst  in  1  reset; synchronous, active-high.
- sw_rst_req  in  1  single-cycle request to re-run the whole sequence.
- rst_out  out  STAGES  per-domain resets, polarity set by ACTIVE_HIGH.
- busy  out  1  high while any stage is asserted.
- done  out  1  one-cycle pulse when the sequence completes.

## Operation
- FSM states:
  - HOLD: all stages asserted; counter runs.
  - RELEASE: stages 0..k-1 released; counter runs toward releasing stage k.
  - RUN: all stages released.
- Stage index k, range 0..STAGES-1.
- Counter cnt: counts 0..HOLD_CYCLES-1. On reaching HOLD_CYCLES-1 with the advance condition true:
  - rst_out[k] deasserts.
  - cnt clears to 0.
  - k increments.
  - The state moves HOLD→RELEASE, or to RUN when the released stage is the last one.
- Advance condition is always true unless RST_SEQ_READY_EN is defined (see Configuration).
- Release is monotonic: once released, a stage stays released until rst or an accepted sw_rst_req.
- sw_rst_req in any state:
  - On the next edge, state→HOLD, cnt=0, k=0, all rst_out asserted.
  - An in-progress sequence restarts from the beginning.
- rst has priority over sw_rst_req and over any pending release at the same edge.
- Every output is registered.

## Timing
- Reset values, for every edge where rst=1:
  - state=HOLD, cnt=0, k=0.
  - rst_out all asserted (all 1s if ACTIVE_HIGH="YES", else all 0s).
  - busy=1, done=0.
- Edge 0 is the first rising edge with rst=0. With the advance condition always true:
  - rst_out[j] deasserts at edge (j+1)·HOLD_CYCLES.
  - This holds for HOLD_CYCLES=1, giving one stage per cycle.
- busy falls at the same edge that rst_out[STAGES-1] deasserts.
- done is high for exactly the one cycle following that edge. It is not reasserted while the block remains in RUN.
- sw_rst_req sampled at edge t:
  - rst_out is fully asserted from edge t+1.
  - busy=1 from edge t+1.
  - The release schedule restarts with edge t+1 as the new edge 0.
- sw_rst_req sampled at the same edge as a scheduled release: the request wins, and the release is not performed.
- rst asserted mid-sequence: the block returns to reset values at that edge. No partial stage release is retained.

## Configuration
- RST_SEQ_READY_EN defined:
  - Adds input port stage_ready, width STAGES, placed after sw_rst_req.
  - Stage k releases only when cnt has reached HOLD_CYCLES-1 and stage_ready[k]=1, e.g. PLL lock for that domain.
  - While stage_ready[k]=0, cnt saturates at HOLD_CYCLES-1 and busy stays 1.
  - A ready bit falling after its stage has released is ignored.
- RST_SEQ_READY_EN undefined:
  - The stage_ready port is absent.
  - The advance condition is constant true; timing is exactly as in Timing.

## Test plan
- STAGES=4, HOLD_CYCLES=16, ACTIVE_HIGH="YES", rst high 5 cycles then low → rst_out goes 4'b1111 → 1110 @16 → 1100 @32 → 1000 @48 → 0000 @64. busy falls @64; done=1 for the single cycle after edge 64.
- ACTIVE_HIGH="NO", same stimulus → rst_out goes 0000 → 0001 @16 → … → 1111 @64. The rst-high value is 0000.
- HOLD_CYCLES=1, STAGES=3 → stages release on edges 1, 2, 3; done one cycle after edge 3.
- Defaults, sw_rst_req pulsed at edge 40 (two stages released) → rst_out=1111 @41; releases @57, 73, 89, 105; only one done pulse, after 105.
- sw_rst_req and rst both high at the same edge in RUN, then rst low → behaviour identical to scenario 1, measured from rst release.
- RST_SEQ_READY_EN defined, stage_ready=4'b1101 until edge 100, then 1111 → stage 0 releases @16; stage 1 releases @101; stage 2 @117; stage 3 @133. cnt holds at 15 while waiting.

Source files
------------

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged reset sequencer, releases STAGES reset outputs HOLD_CYCLES apart.
// Optional per-stage ready gating when RST_SEQ_READY_EN is defined.
module rst_sequencer #(
  parameter int STAGES      = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 8,
  parameter     ACTIVE_HIGH = "YES"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
`ifdef RST_SEQ_READY_EN
  input  logic [STAGES-1:0] stage_ready,
`endif
  output logic [STAGES-1:0] rst_out,
  output logic              busy,
  output logic              done
);

  localparam int               K_W      = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(STAGES - 1);
  localparam logic             ASSERTED = (ACTIVE_HIGH == "YES");

  if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
    $error("rst_sequencer: STAGES must be in 1..16");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("rst_sequencer: HOLD_CYCLES must be at least 1");
  end
  if ((longint'(HOLD_CYCLES) - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("rst_sequencer: CNT_W too narrow for HOLD_CYCLES");
  end

  typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [K_W-1:0]   k;
  logic             armed;
  logic             advance;

`ifdef RST_SEQ_READY_EN
  assign advance = stage_ready[k];
`else
  assign advance = 1'b1;
`endif

  // The first edge after any reset only arms the counter, so stage j
  // releases exactly (j+1)*HOLD_CYCLES edges after the reset is dropped.
  always_ff @(posedge clk) begin
    if (rst || sw_rst_req) begin
      state   <= HOLD;
      cnt     <= '0;
      k       <= '0;
      armed   <= 1'b0;
      rst_out <= {STAGES{ASSERTED}};
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done  <= 1'b0;
      armed <= 1'b1;
      if (armed && state != RUN) begin
        if (cnt == CNT_LAST) begin
          // Without ready, cnt simply stays saturated at CNT_LAST.
          if (advance) begin
            rst_out[k] <= ~ASSERTED;
            cnt        <= '0;
            if (k == K_LAST) begin
              state <= RUN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              k     <= k + 1'b1;
              state <= RELEASE;
            end
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - scoreboard bench for rst_sequencer across three parameter sets.
module tb_rst_sequencer;

  typedef struct {
    logic [5:0] a;
    logic [5:0] b;
    logic [4:0] c;
    int         e;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_rst_req = 1'b0;
  logic [3:0] out_a, out_b;
  logic [2:0] out_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
`ifdef RST_SEQ_READY_EN
  logic [3:0] stage_ready = 4'b1111;
  logic [3:0] ready_all = 4'b1111;
`endif

  int   checks = 0;
  int   failures = 0;
  int   e = -1;
  bit   ready_mode = 1'b0;
  exp_t q[$];

  rst_sequencer dut_a (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
`ifdef RST_SEQ_READY_EN
    .stage_ready(stage_ready),
`endif
    .rst_out(out_a), .busy(busy_a), .done(done_a)
  );

  rst_sequencer #(.ACTIVE_HIGH("NO")) dut_b (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
`ifdef RST_SEQ_READY_EN
    .stage_ready(ready_all),
`endif
    .rst_out(out_b), .busy(busy_b), .done(done_b)
  );

  rst_sequencer #(.STAGES(3), .HOLD_CYCLES(1)) dut_c (
    .clk(clk), .rst(rst), .sw_rst_req(sw_rst_req),
`ifdef RST_SEQ_READY_EN
    .stage_ready(ready_all[2:0]),
`endif
    .rst_out(out_c), .busy(busy_c), .done(done_c)
  );

  always #5 clk = ~clk;

  // Schedule-based reference: e is the edge index since the last reset edge (-1 = reset edge).
  function automatic void model(input int ev, input int s, input int h, input logic pol,
                                output logic [15:0] o, output logic b, output logic d);
    int rel;
    rel = (ev < 0) ? 0 : ((ev / h > s) ? s : ev / h);
    for (int j = 0; j < 16; j++) o[j] = (j < rel) ? ~pol : pol;
    b = (rel < s);
    d = (ev == s * h);
  endfunction

  function automatic void model_ready(input int ev, output logic [15:0] o,
                                      output logic b, output logic d);
    int rel;
    rel = 0;
    if (ev >= 16)  rel = 1;
    if (ev >= 101) rel = 2;
    if (ev >= 117) rel = 3;
    if (ev >= 133) rel = 4;
    for (int j = 0; j < 16; j++) o[j] = (j < rel) ? 1'b0 : 1'b1;
    b = (rel < 4);
    d = (ev == 133);
  endfunction

  task automatic drive(input logic r, input logic s);
    exp_t        x;
    logic [15:0] o;
    logic        b, d;
    rst = r;
    sw_rst_req = s;
    e = (r || s) ? -1 : e + 1;
`ifdef RST_SEQ_READY_EN
    stage_ready = (ready_mode && e <= 100) ? 4'b1101 : 4'b1111;
`endif
    x.e = e;
    if (ready_mode) model_ready(e, o, b, d);
    else            model(e, 4, 16, 1'b1, o, b, d);
    x.a = {o[3:0], b, d};
    model(e, 4, 16, 1'b0, o, b, d);
    x.b = {o[3:0], b, d};
    model(e, 3, 1, 1'b1, o, b, d);
    x.c = {o[2:0], b, d};
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t x;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0);
      x = q.pop_front();
      checks++;
      if ({out_a, busy_a, done_a} !== x.a) begin failures++; $display("FAIL reset_a edge=%0d got=%b exp=%b", x.e, {out_a, busy_a, done_a}, x.a); end
      checks++;
      if ({out_b, busy_b, done_b} !== x.b) begin failures++; $display("FAIL reset_b edge=%0d got=%b exp=%b", x.e, {out_b, busy_b, done_b}, x.b); end
      checks++;
      if ({out_c, busy_c, done_c} !== x.c) begin failures++; $display("FAIL reset_c edge=%0d got=%b exp=%b", x.e, {out_c, busy_c, done_c}, x.c); end
    end
  endtask

  task automatic test_sequence();
    exp_t x;
    for (int i = 0; i < 70; i++) begin
      drive(1'b0, 1'b0);
      x = q.pop_front();
      checks++;
      if ({out_a, busy_a, done_a} !== x.a) begin failures++; $display("FAIL seq_a edge=%0d got=%b exp=%b", x.e, {out_a, busy_a, done_a}, x.a); end
      checks++;
      if ({out_b, busy_b, done_b} !== x.b) begin failures++; $display("FAIL seq_b edge=%0d got=%b exp=%b", x.e, {out_b, busy_b, done_b}, x.b); end
      checks++;
      if ({out_c, busy_c, done_c} !== x.c) begin failures++; $display("FAIL seq_c edge=%0d got=%b exp=%b", x.e, {out_c, busy_c, done_c}, x.c); end
    end
  endtask

  // sw_rst_req at a chosen edge after a fresh reset, then run the whole restarted sequence.
  task automatic test_sw_restart(input int req_edge, input string tag);
    exp_t x;
    bit   fired;
    fired = 1'b0;
    for (int i = 0; i < req_edge + 75; i++) begin
      if (i < 2) drive(1'b1, 1'b0);
      else if (!fired && e + 1 == req_edge) begin drive(1'b0, 1'b1); fired = 1'b1; end
      else drive(1'b0, 1'b0);
      x = q.pop_front();
      checks++;
      if ({out_a, busy_a, done_a} !== x.a) begin failures++; $display("FAIL %s_a edge=%0d got=%b exp=%b", tag, x.e, {out_a, busy_a, done_a}, x.a); end
      checks++;
      if ({out_b, busy_b, done_b} !== x.b) begin failures++; $display("FAIL %s_b edge=%0d got=%b exp=%b", tag, x.e, {out_b, busy_b, done_b}, x.b); end
      checks++;
      if ({out_c, busy_c, done_c} !== x.c) begin failures++; $display("FAIL %s_c edge=%0d got=%b exp=%b", tag, x.e, {out_c, busy_c, done_c}, x.c); end
    end
  endtask

  task automatic test_rst_and_sw();
    exp_t x;
    for (int i = 0; i < 71; i++) begin
      if (i == 0) drive(1'b1, 1'b1);
      else        drive(1'b0, 1'b0);
      x = q.pop_front();
      checks++;
      if ({out_a, busy_a, done_a} !== x.a) begin failures++; $display("FAIL rst_sw_a edge=%0d got=%b exp=%b", x.e, {out_a, busy_a, done_a}, x.a); end
      checks++;
      if ({out_b, busy_b, done_b} !== x.b) begin failures++; $display("FAIL rst_sw_b edge=%0d got=%b exp=%b", x.e, {out_b, busy_b, done_b}, x.b); end
      checks++;
      if ({out_c, busy_c, done_c} !== x.c) begin failures++; $display("FAIL rst_sw_c edge=%0d got=%b exp=%b", x.e, {out_c, busy_c, done_c}, x.c); end
    end
  endtask

  task automatic test_rst_mid();
    exp_t x;
    bit   fired;
    fired = 1'b0;
    for (int i = 0; i < 110; i++) begin
      if (!fired && e + 1 == 40) begin drive(1'b1, 1'b0); fired = 1'b1; end
      else drive(1'b0, 1'b0);
      x = q.pop_front();
      checks++;
      if ({out_a, busy_a, done_a} !== x.a) begin failures++; $display("FAIL rst_mid_a edge=%0d got=%b exp=%b", x.e, {out_a, busy_a, done_a}, x.a); end
      checks++;
      if ({out_b, busy_b, done_b} !== x.b) begin failures++; $display("FAIL rst_mid_b edge=%0d got=%b exp=%b", x.e, {out_b, busy_b, done_b}, x.b); end
      checks++;
      if ({out_c, busy_c, done_c} !== x.c) begin failures++; $display("FAIL rst_mid_c edge=%0d got=%b exp=%b", x.e, {out_c, busy_c, done_c}, x.c); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    for (int i = 0; i < 95; i++) begin
      if (i == 20 || i == 21) drive(1'b0, 1'b1);
      else                    drive(1'b0, 1'b0);
      x = q.pop_front();
      checks++;
      if ({out_a, busy_a, done_a} !== x.a) begin failures++; $display("FAIL b2b_a edge=%0d got=%b exp=%b", x.e, {out_a, busy_a, done_a}, x.a); end
      checks++;
      if ({out_b, busy_b, done_b} !== x.b) begin failures++; $display("FAIL b2b_b edge=%0d got=%b exp=%b", x.e, {out_b, busy_b, done_b}, x.b); end
      checks++;
      if ({out_c, busy_c, done_c} !== x.c) begin failures++; $display("FAIL b2b_c edge=%0d got=%b exp=%b", x.e, {out_c, busy_c, done_c}, x.c); end
    end
  endtask

`ifdef RST_SEQ_READY_EN
  task automatic test_stage_ready();
    exp_t x;
    ready_mode = 1'b1;
    for (int i = 0; i < 145; i++) begin
      if (i < 2) drive(1'b1, 1'b0);
      else       drive(1'b0, 1'b0);
      x = q.pop_front();
      checks++;
      if ({out_a, busy_a, done_a} !== x.a) begin failures++; $display("FAIL ready_a edge=%0d got=%b exp=%b", x.e, {out_a, busy_a, done_a}, x.a); end
    end
    ready_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_sequence();
    test_sw_restart(40, "sw40");
    test_sw_restart(32, "sw_on_release");
    test_rst_and_sw();
    test_rst_mid();
    test_back_to_back();
`ifdef RST_SEQ_READY_EN
    test_stage_ready();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
